sram_word_ctrl: RTL and testbench

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

---
 rtl/sram_word_ctrl.sv | 148 ++++++++++++++
 tb/tb_sram_word_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_ctrl.sv
// 32-bit word access over a 16-bit async SRAM, two half-word phases per access.
// Define SRAM_CTRL_WAITSTATE_EN to add one hold cycle after each strobe phase.
module sram_word_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_bmask,
    input  logic        i_rden,
    input  logic        i_wren,
    output logic [31:0] o_data,
    output logic        o_ack,
    output logic        o_stall,
    output logic [17:0] o_SRAM_ADDR,
    inout  wire  [15:0] o_SRAM_DQ,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LO_A = 3'd1;
    localparam logic [2:0] LO_B = 3'd2;
    localparam logic [2:0] HI_A = 3'd3;
    localparam logic [2:0] HI_B = 3'd4;
    localparam logic [2:0] ACK  = 3'd5;
`ifdef SRAM_CTRL_WAITSTATE_EN
    localparam logic [2:0] LO_W = 3'd6;
    localparam logic [2:0] HI_W = 3'd7;
`endif

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [16:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  bmask_q;
    logic        wr_q;
    logic        req;
    logic        lo_phase;
    logic        hi_phase;
    logic        a_phase;
    logic        active;
    logic        half_en;
    logic [15:0] dq_out;
    logic        dq_drive;
    logic        unused;

    assign unused = ^{i_addr[31:19], i_addr[1:0]};
    assign req    = i_rden | i_wren;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req ? LO_A : IDLE;
`ifdef SRAM_CTRL_WAITSTATE_EN
            LO_A:    next_state = LO_W;
            LO_W:    next_state = LO_B;
            HI_A:    next_state = HI_W;
            HI_W:    next_state = HI_B;
`else
            LO_A:    next_state = LO_B;
            HI_A:    next_state = HI_B;
`endif
            LO_B:    next_state = HI_A;
            HI_B:    next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields are frozen at acceptance; write wins over read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            bmask_q <= '0;
            wr_q    <= 1'b0;
        end else if (state == IDLE && req) begin
            addr_q  <= i_addr[18:2];
            data_q  <= i_data;
            bmask_q <= i_bmask;
            wr_q    <= i_wren;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (!wr_q && state == LO_B) begin
            o_data[15:0] <= o_SRAM_DQ;
        end else if (!wr_q && state == HI_B) begin
            o_data[31:16] <= o_SRAM_DQ;
        end
    end

`ifdef SRAM_CTRL_WAITSTATE_EN
    assign lo_phase = (state == LO_A) || (state == LO_W) || (state == LO_B);
    assign hi_phase = (state == HI_A) || (state == HI_W) || (state == HI_B);
    assign a_phase  = (state == LO_A) || (state == LO_W) ||
                      (state == HI_A) || (state == HI_W);
`else
    assign lo_phase = (state == LO_A) || (state == LO_B);
    assign hi_phase = (state == HI_A) || (state == HI_B);
    assign a_phase  = (state == LO_A) || (state == HI_A);
`endif

    assign active  = lo_phase | hi_phase;
    // A half with no enabled bytes gets no write pulse at all.
    assign half_en = hi_phase ? |bmask_q[3:2] : |bmask_q[1:0];

    assign o_SRAM_ADDR = active ? {addr_q, hi_phase} : 18'd0;
    assign o_SRAM_CE_N = ~active;
    assign o_SRAM_OE_N = ~(active & ~wr_q);
    assign o_SRAM_WE_N = ~(active & wr_q & a_phase & half_en);

    always_comb begin
        o_SRAM_LB_N = 1'b1;
        o_SRAM_UB_N = 1'b1;
        if (active && !wr_q) begin
            o_SRAM_LB_N = 1'b0;
            o_SRAM_UB_N = 1'b0;
        end else if (active && hi_phase) begin
            o_SRAM_LB_N = ~bmask_q[2];
            o_SRAM_UB_N = ~bmask_q[3];
        end else if (active) begin
            o_SRAM_LB_N = ~bmask_q[0];
            o_SRAM_UB_N = ~bmask_q[1];
        end
    end

    assign dq_drive  = active & wr_q;
    assign dq_out    = hi_phase ? data_q[31:16] : data_q[15:0];
    assign o_SRAM_DQ = dq_drive ? dq_out : 16'hzzzz;

    assign o_ack   = (state == ACK);
    assign o_stall = req & ~o_ack & ~i_rst;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl with a behavioural 16-bit SRAM.
// Honours SRAM_CTRL_WAITSTATE_EN for latency and strobe-length expectations.
module tb_sram_word_ctrl;

`ifdef SRAM_CTRL_WAITSTATE_EN
    localparam int LAT    = 7;
    localparam int WE_PER = 2;
    localparam int TO_HIA = 4;
`else
    localparam int LAT    = 5;
    localparam int WE_PER = 1;
    localparam int TO_HIA = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [3:0]  i_bmask;
    logic        i_rden;
    logic        i_wren;
    logic [31:0] o_data;
    logic        o_ack;
    logic        o_stall;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    logic [15:0] mem [0:262143];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sram_word_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_bmask     (i_bmask),
        .i_rden      (i_rden),
        .i_wren      (i_wren),
        .o_data      (o_data),
        .o_ack       (o_ack),
        .o_stall     (o_stall),
        .o_SRAM_ADDR (sram_addr),
        .o_SRAM_DQ   (dq),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    // SRAM model: drives reads combinationally, latches writes per lane.
    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr][7:0]  <= dq[7:0];
            if (!ub_n) mem[sram_addr][15:8] <= dq[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] bm, output int lat,
                           output logic [31:0] rdata, output int we_lo,
                           output int we_hi);
        lat   = 0;
        we_lo = 0;
        we_hi = 0;
        rdata = '0;
        @(negedge clk);
        chk("ack_one_cycle", {31'd0, o_ack}, 0);
        i_rden  = rd;
        i_wren  = wr;
        i_addr  = addr;
        i_data  = data;
        i_bmask = bm;
        #1 chk("stall_accept", {31'd0, o_stall}, 1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_ack) begin
                lat   = k;
                rdata = o_data;
                chk("stall_at_ack", {31'd0, o_stall}, 0);
                i_rden = 1'b0;
                i_wren = 1'b0;
                break;
            end
            chk("stall_busy", {31'd0, o_stall}, 1);
            chk("ce_n_busy", {31'd0, ce_n}, 0);
            chk("sram_word", {15'd0, sram_addr[17:1]}, {15'd0, addr[18:2]});
            if (wr) begin
                chk("oe_n_wr", {31'd0, oe_n}, 1);
                if (!we_n && sram_addr[0]) begin
                    we_hi++;
                    chk("dq_hi", {16'd0, dq}, {16'd0, data[31:16]});
                    chk("lanes_hi", {30'd0, ub_n, lb_n}, {30'd0, ~bm[3:2]});
                end else if (!we_n) begin
                    we_lo++;
                    chk("dq_lo", {16'd0, dq}, {16'd0, data[15:0]});
                    chk("lanes_lo", {30'd0, ub_n, lb_n}, {30'd0, ~bm[1:0]});
                end
            end else begin
                chk("oe_n_rd", {31'd0, oe_n}, 0);
                chk("we_n_rd", {31'd0, we_n}, 1);
                chk("lanes_rd", {30'd0, ub_n, lb_n}, 0);
            end
            i_addr  = ~addr;
            i_data  = ~data;
            i_bmask = ~bm;
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got none expected ack");
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bm;
        logic [31:0] exp;
        int          we_lo;
        int          we_hi;
    } vec_t;

    vec_t        vecs [10];
    int          lat, wl, wh, gap;
    logic [31:0] rdata;
    logic        seen;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0, 1, 1};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h12345678, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 32'h100, 32'hAABBCCDD, 4'h4, 32'h0, 0, 1};
        vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h12BB5678, 0, 0};
        vecs[4] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 32'h0, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0};
        vecs[8] = '{1'b0, 1'b1, 32'h307, 32'hCAFEF00D, 4'h3, 32'h0, 1, 0};
        vecs[9] = '{1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 32'h0000F00D, 0, 0};

        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        rst     = 1'b1;
        i_rden  = 1'b1;
        i_wren  = 1'b0;
        i_addr  = 32'h100;
        i_data  = 32'h0;
        i_bmask = 4'h0;

        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, o_ack}, 0);
        chk("rst_data", o_data, 0);
        chk("rst_addr", {14'd0, sram_addr}, 0);
        chk("rst_strobes", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        chk("rst_stall", {31'd0, o_stall}, 0);
        chk("rst_dq_z", {31'd0, dq === 16'hzzzz}, 1);
        rst    = 1'b0;
        i_rden = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].bm, lat, rdata, wl, wh);
            chk($sformatf("latency_v%0d", i), lat, LAT);
            chk($sformatf("we_lo_v%0d", i), wl, vecs[i].we_lo * WE_PER);
            chk($sformatf("we_hi_v%0d", i), wh, vecs[i].we_hi * WE_PER);
            if (!vecs[i].wr) chk($sformatf("rdata_v%0d", i), rdata, vecs[i].exp);
        end

        @(negedge clk);
        chk("idle_ack", {31'd0, o_ack}, 0);
        chk("idle_dq_z", {31'd0, dq === 16'hzzzz}, 1);
        chk("mem_080", {16'd0, mem[18'h080]}, 32'h5678);
        chk("mem_081", {16'd0, mem[18'h081]}, 32'h12BB);
        chk("mem_100", {16'd0, mem[18'h100]}, 32'hBEEF);
        chk("mem_101", {16'd0, mem[18'h101]}, 32'hDEAD);
        chk("mem_182", {16'd0, mem[18'h182]}, 32'hF00D);
        chk("mem_183", {16'd0, mem[18'h183]}, 32'h0000);

        // Reset asserted mid-cycle while the upper half strobe is active.
        i_wren  = 1'b1;
        i_addr  = 32'h100;
        i_data  = 32'h55554444;
        i_bmask = 4'hF;
        repeat (TO_HIA) @(negedge clk);
        chk("abort_in_hi_a", {30'd0, sram_addr[0], we_n}, 32'h2);
        #1 rst  = 1'b1;
        i_wren  = 1'b0;
        #1;
        chk("abort_strobes", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        chk("abort_dq_z", {31'd0, dq === 16'hzzzz}, 1);
        chk("abort_addr", {14'd0, sram_addr}, 0);
        chk("abort_data", o_data, 0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | o_ack;
        end
        chk("abort_no_ack", {31'd0, seen}, 0);
        chk("abort_mem_lo", {16'd0, mem[18'h080]}, 32'h4444);
        chk("abort_mem_hi", {16'd0, mem[18'h081]}, 32'h12BB);
        @(posedge clk);
        #2 rst = 1'b0;
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rdata, wl, wh);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_rdata", rdata, 32'h12BB4444);

        // Request held through ACK restarts straight from IDLE.
        @(negedge clk);
        i_rden = 1'b1;
        i_addr = 32'h200;
        seen   = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = o_ack;
        end
        chk("b2b_first_ack", {31'd0, seen}, 1);
        gap = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (o_ack) begin
                seen = 1'b1;
                gap  = k;
            end
        end
        i_rden = 1'b0;
        chk("b2b_gap", gap, LAT + 1);
        chk("b2b_rdata", o_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("b2b_done", {31'd0, o_ack}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
